// File: rtl/pe_loader.sv
// pe_loader: stream-side feeder for the 1-D convolution PE.
// Collects a valid/ready word stream into the PE's parallel weight and data
// vectors. It then holds the PE enabled until done and pulses frame_done.
// Optional RUN watchdog: define PE_LOADER_TIMEOUT_EN to build the timeout
// counter and the sticky err flag. Without it, err is tied low and RUN waits
// for pe_done indefinitely.
module pe_loader #(
    parameter int DATA_WIDTH     = 8,
    parameter int INPUT_SIZE     = 8,
    parameter int WEIGHT_SIZE    = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                  clk_i,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  reload_w,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [DATA_WIDTH-1:0]                 s_data,
    output logic [WEIGHT_SIZE-1:0][DATA_WIDTH-1:0] weight_out,
    output logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  data_out,
    output logic                                  pe_en,
    input  logic                                  pe_done,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic                                  err,
    input  logic                                  clr_err
);

    localparam int WIW = (WEIGHT_SIZE > 1) ? $clog2(WEIGHT_SIZE) : 1;
    localparam int DIW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

    localparam logic [WIW-1:0] W_LAST = WIW'(WEIGHT_SIZE - 1);
    localparam logic [DIW-1:0] D_LAST = DIW'(INPUT_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_D,
        RUN,
        FIN
    } state_e;

    state_e state_q, state_d;

    logic [WEIGHT_SIZE-1:0][DATA_WIDTH-1:0] weight_q;
    logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  data_q;
    logic [WIW-1:0]                         widx_q;
    logic [DIW-1:0]                         didx_q;
    logic                                   w_valid_q;
    logic                                   accept;
    logic                                   w_last_acc;
    logic                                   d_last_acc;
    logic                                   timeout;

    // Ready is decoded from state alone, so no input reaches any output
    assign s_ready    = (state_q == LOAD_W) || (state_q == LOAD_D);
    assign pe_en      = (state_q == RUN);
    assign frame_done = (state_q == FIN);
    assign busy       = (state_q != IDLE);
    assign weight_out = weight_q;
    assign data_out   = data_q;

    assign accept     = s_valid && s_ready;
    assign w_last_acc = accept && (state_q == LOAD_W) && (widx_q == W_LAST);
    assign d_last_acc = accept && (state_q == LOAD_D) && (didx_q == D_LAST);

`ifdef PE_LOADER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] run_cnt_q;
    logic          err_q;

    // pe_done takes priority over a timeout in the same cycle
    assign timeout = (state_q == RUN) && !pe_done && (run_cnt_q == CNT_LAST);
    assign err     = err_q;

    // RUN cycle counter; zero outside RUN so it starts clean on entry
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            run_cnt_q <= '0;
        end else if (state_q != RUN) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
        end
    end

    // Sticky error flag; a fresh timeout wins over clr_err
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end else if (clr_err) begin
            err_q <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign err        = 1'b0;
    assign unused_cfg = clr_err ^ TIMEOUT_CYCLES[0];
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (reload_w || !w_valid_q) ? LOAD_W : LOAD_D;
                end
            end
            LOAD_W: begin
                if (w_last_acc) begin
                    state_d = LOAD_D;
                end
            end
            LOAD_D: begin
                if (d_last_acc) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (pe_done) begin
                    state_d = FIN;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Weight index and the weights-loaded flag
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            widx_q    <= '0;
            w_valid_q <= 1'b0;
        end else if (accept && (state_q == LOAD_W)) begin
            if (widx_q == W_LAST) begin
                widx_q    <= '0;
                w_valid_q <= 1'b1;
            end else begin
                widx_q <= widx_q + 1'b1;
            end
        end
    end

    // Data index
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            didx_q <= '0;
        end else if (accept && (state_q == LOAD_D)) begin
            if (didx_q == D_LAST) begin
                didx_q <= '0;
            end else begin
                didx_q <= didx_q + 1'b1;
            end
        end
    end

    // Weight vector: written only by accepted words in LOAD_W
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            weight_q <= '0;
        end else if (accept && (state_q == LOAD_W)) begin
            weight_q[widx_q] <= s_data;
        end
    end

    // Data vector: written only by accepted words in LOAD_D
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else if (accept && (state_q == LOAD_D)) begin
            data_q[didx_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_pe_loader.sv
// Self-checking bench for pe_loader: directed frames plus randomized frames
// with random valid gaps, checked against a frame-level reference model.
module tb_pe_loader;

    localparam int DW = 8;
    localparam int IS = 8;
    localparam int WS = 3;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic reload_w = 1'b0;
    logic s_valid = 1'b0;
    logic pe_done = 1'b0;
    logic clr_err = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic s_ready, pe_en, busy, frame_done, err;
    logic [WS-1:0][DW-1:0] weight_out;
    logic [IS-1:0][DW-1:0] data_out;

    int vecs = 0;
    int errs = 0;

    // Reference model state
    logic [DW-1:0] w_exp [WS];
    logic [DW-1:0] d_exp [IS];
    bit wv_m = 0;
    bit err_m = 0;
    bit need_w = 0;
    int k = 0;
    bit rnd = 0;
    int base_w = 0;
    int base_d = 0;

    pe_loader #(
        .DATA_WIDTH(DW),
        .INPUT_SIZE(IS),
        .WEIGHT_SIZE(WS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst(rst),
        .start(start),
        .reload_w(reload_w),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .weight_out(weight_out),
        .data_out(data_out),
        .pe_en(pe_en),
        .pe_done(pe_done),
        .busy(busy),
        .frame_done(frame_done),
        .err(err),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] wpack();
        logic [63:0] r = '0;
        for (int i = 0; i < WS; i++) r[i*DW +: DW] = w_exp[i];
        return r;
    endfunction

    function automatic logic [63:0] dpack();
        logic [63:0] r = '0;
        for (int i = 0; i < IS; i++) r[i*DW +: DW] = d_exp[i];
        return r;
    endfunction

    function automatic logic [DW-1:0] make_word(input int idx);
        if (rnd) return DW'($urandom);
        if (need_w && idx < WS) return DW'(base_w + idx);
        return DW'(base_d + idx - (need_w ? WS : 0));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < WS; i++) w_exp[i] = '0;
        for (int i = 0; i < IS; i++) d_exp[i] = '0;
        wv_m = 0;
        err_m = 0;
    endtask

    // Stream words until the frame has accepted 'target' words in total
    task automatic feed(input int target, input bit gaps);
        int cyc = 0;
        while (k < target && cyc < 500) begin
            s_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            s_data  = make_word(k);
            chk("s_ready_load", s_ready, 1);
            if (s_valid && s_ready) begin
                if (need_w && k < WS) begin
                    w_exp[k] = s_data;
                    if (k == WS - 1) wv_m = 1;
                end else begin
                    d_exp[k - (need_w ? WS : 0)] = s_data;
                end
                k++;
            end
            step();
            cyc++;
        end
        s_valid = 1'b0;
        chk("load_in_budget", 64'(k >= target), 1);
    endtask

    task automatic begin_frame(input bit reload, input bit stale);
        chk("idle_busy", busy, 0);
        chk("idle_s_ready", s_ready, 0);
        chk("idle_pe_en", pe_en, 0);
        chk("err_level", err, 64'(err_m));
        start    = 1'b1;
        reload_w = reload;
        pe_done  = stale;
        step();
        start    = 1'b0;
        reload_w = 1'b0;
        need_w   = reload || !wv_m;
        k        = 0;
        chk("s_ready_after_start", s_ready, 1);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic frame(input bit reload, input bit gaps, input bit stale,
                         input bit random_words, input int bw, input int bd);
        rnd    = random_words;
        base_w = bw;
        base_d = bd;
        begin_frame(reload, stale);
        feed((need_w ? WS : 0) + IS, gaps);
        pe_done = 1'b0;
        chk("pe_en_after_last", pe_en, 1);
        chk("s_ready_in_run", s_ready, 0);
        chk("weight_out", weight_out, wpack());
        chk("data_out", data_out, dpack());
        start = 1'b1;
        step();
        start = 1'b0;
        chk("run_ignores_start", pe_en, 1);
        repeat ($urandom_range(0, 4)) begin
            step();
            chk("run_hold", pe_en, 1);
            chk("run_no_fd", frame_done, 0);
        end
        pe_done = 1'b1;
        step();
        pe_done = stale;
        chk("fin_frame_done", frame_done, 1);
        chk("fin_pe_en", pe_en, 0);
        chk("fin_busy", busy, 1);
        step();
        chk("fd_one_cycle", frame_done, 0);
        chk("idle_after_fin", busy, 0);
        chk("weights_kept", weight_out, wpack());
        chk("data_kept", data_out, dpack());
    endtask

    initial begin
        model_clear();
        repeat (3) step();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_pe_en", pe_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err, 0);
        chk("rst_weights", weight_out, 0);
        chk("rst_data", data_out, 0);
        rst = 1'b1;
        step();

        // No weights yet: reload_w=0 still loads weights 1,2,3 then 10..17
        frame(0, 0, 0, 0, 1, 10);
        // Weights reused, data 20..27 only
        frame(0, 0, 0, 0, 0, 20);
        // Valid gaps and random words
        frame(0, 1, 0, 1, 0, 0);
        // Forced reload with pe_done left high through IDLE and load
        frame(1, 1, 1, 1, 0, 0);
        frame(0, 1, 1, 1, 0, 0);

        // Reset during LOAD_D after four data words
        begin_frame(0, 0);
        feed(4, 1);
        rst = 1'b0;
        #1;
        model_clear();
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_pe_en", pe_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_fd", frame_done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_weights", weight_out, 0);
        chk("mid_rst_data", data_out, 0);
        step();
        rst = 1'b1;
        step();
        // w_valid cleared by reset, so weights must load again
        frame(0, 1, 0, 1, 0, 0);

`ifdef PE_LOADER_TIMEOUT_EN
        begin
            int cnt = 0;
            rnd = 1;
            begin_frame(0, 0);
            feed((need_w ? WS : 0) + IS, 1);
            pe_done = 1'b0;
            while (pe_en === 1'b1 && cnt < 100) begin
                chk("to_no_fd", frame_done, 0);
                cnt++;
                step();
            end
            chk("to_run_cycles", cnt, TO);
            err_m = 1;
            chk("to_err_set", err, 1);
            chk("to_fd_low", frame_done, 0);
            chk("to_idle", busy, 0);
            repeat (3) begin
                step();
                chk("to_err_sticky", err, 1);
            end
            clr_err = 1'b1;
            step();
            clr_err = 1'b0;
            err_m = 0;
            chk("to_err_clear", err, 0);
        end
`endif

        for (int i = 0; i < 6; i++) begin
            frame(1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 1, 0, 0);
        end
        pe_done = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/pe_loader.md
# pe_loader

Stream-side feeder for the 1-D convolution processing element. Accepts a serial valid/ready word stream and assembles it into the PE's parallel `weight_in` and `data_in` vectors. It then drives the PE enable and holds the vectors stable until the PE reports `done`. It sits between the upstream buffer/DMA and `pe`, and is the write side of the PE's parallel-load/done interface.

## Interface
Parameters:
- DATA_WIDTH, default `DATA_WIDTH (8): width of one data/weight word.
- INPUT_SIZE, default `INPUT_SIZE (8): number of data words per frame.
- WEIGHT_SIZE, default `WEIGHT_SIZE (3): number of weight words.
- TIMEOUT_CYCLES, default 1024: maximum RUN cycles before abort; used only with the timeout feature.

Ports:
- clk_i, in, 1: the block's single clock.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a frame; sampled in IDLE only.
- reload_w, in, 1: sampled with start; 1 = frame begins with WEIGHT_SIZE weight words.
- s_valid, in, 1: stream word valid.
- s_ready, out, 1: stream word accepted when s_valid && s_ready.
- s_data, in, DATA_WIDTH: stream word.
- weight_out, out, DATA_WIDTH x WEIGHT_SIZE: to PE weight_in.
- data_out, out, DATA_WIDTH x INPUT_SIZE: to PE data_in.
- pe_en, out, 1: to PE en.
- pe_done, in, 1: from PE done.
- busy, out, 1: high in every state except IDLE.
- frame_done, out, 1: one-cycle pulse on PE completion.
- err, out, 1: sticky timeout flag; tied 0 without the timeout feature.
- clr_err, in, 1: clears err.

## Operation
- States: IDLE, LOAD_W, LOAD_D, RUN, FIN.
- IDLE:
  - start=1 goes to LOAD_W if reload_w=1 or no weights have been loaded since reset (internal w_valid=0).
  - Otherwise start=1 goes to LOAD_D.
- LOAD_W:
  - s_ready=1. Each accepted word is written to weight_out[widx], and widx increments from 0.
  - On acceptance at widx=WEIGHT_SIZE-1: set w_valid, clear widx, go to LOAD_D.
- LOAD_D:
  - Same scheme with didx into data_out.
  - On acceptance at didx=INPUT_SIZE-1: go to RUN.
- RUN:
  - pe_en=1 and s_ready=0. weight_out and data_out are held stable.
  - pe_done=1 goes to FIN.
- FIN: pe_en=0 and frame_done=1 for one cycle, then IDLE.
- pe_done is ignored outside RUN, including a stale high level left from a previous frame.
- start outside IDLE is ignored.
- Vectors are written only by accepted words. They keep their values across frames and across IDLE.
- s_valid gaps stall the load. The index counters hold while no word is accepted.

## Timing
- Reset values: state IDLE, s_ready 0, pe_en 0, busy 0, frame_done 0, err 0, all vector entries 0, indices 0, w_valid 0.
- Asserting rst mid-frame returns the block to IDLE immediately with the values above.
- All outputs are registered or decoded from registered state only. There is no combinational path from s_valid, start or pe_done to any output.
- Cycle relations:
  - start at cycle t gives s_ready=1 at t+1.
  - Last data word accepted at cycle t gives pe_en=1 from t+1.
  - pe_done sampled high at cycle t gives pe_en=0 and frame_done=1 at t+1, and busy=0 at t+2.
  - The next start is accepted at t+2.
- Minimum frame cost with s_valid held high: 1 + WEIGHT_SIZE + INPUT_SIZE + PE latency + 1 cycles.

## Configuration
- Macro: PE_LOADER_TIMEOUT_EN.
- When defined:
  - A RUN cycle counter clears on RUN entry.
  - If TIMEOUT_CYCLES cycles elapse in RUN without pe_done, the block sets err=1, drops pe_en, returns to IDLE, and does not pulse frame_done.
  - err stays set until clr_err=1 or reset. clr_err and a new timeout in the same cycle leave err=1.
- When undefined:
  - No counter is built and err is constant 0.
  - RUN waits indefinitely for pe_done.

## Test plan
- Reset, start=1, reload_w=0 with no prior load -> LOAD_W entered. Weights 1,2,3 and data 10..17 appear on weight_out/data_out. pe_en rises the cycle after word 17 is accepted.
- Second frame, start with reload_w=0, data 20..27 -> no weight phase, weight_out stays 1,2,3, exactly 8 words accepted.
- s_valid toggles every other cycle during load -> indices advance only on accepted words and final vectors match the input.
- pe_done held high through IDLE and LOAD -> ignored. In RUN, pe_done pulse at cycle t -> frame_done=1 at t+1 only, busy=0 at t+2.
- rst low during LOAD_D after 4 words -> all outputs 0 the same cycle. After release a fresh start reloads weights (w_valid cleared).
- With PE_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=16 and pe_done never asserted -> pe_en drops after 16 RUN cycles, err=1 and stays 1, no frame_done, and clr_err pulse -> err=0.
